// File: rtl/uart_param_if.sv
// Bus-side handshake of uart_param: TX write port and RX result/status port.
// The rx_break member exists only when UART_BREAK_DETECT_EN is defined.
interface uart_param_if #(
  parameter int unsigned DATA_BITS = 8
);
  logic                 we;
  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_busy;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_busy;
  logic                 rx_error;
  logic                 rx_parity_err;
`ifdef UART_BREAK_DETECT_EN
  logic                 rx_break;
`endif

  modport master (
`ifdef UART_BREAK_DETECT_EN
    input  rx_break,
`endif
    output we, tx_data,
    input  tx_busy, rx_data, rx_valid, rx_busy, rx_error, rx_parity_err
  );

  modport slave (
`ifdef UART_BREAK_DETECT_EN
    output rx_break,
`endif
    input  we, tx_data,
    output tx_busy, rx_data, rx_valid, rx_busy, rx_error, rx_parity_err
  );
endinterface

// File: rtl/uart_param.sv
// Parametrised full-duplex UART with independent TX/RX engines and error reporting.
// Optional break detection on RX is enabled by defining UART_BREAK_DETECT_EN.
module uart_param #(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY     = 0,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [15:0] i_prescale,
  output logic        o_tx,
  input  logic        i_rx,
  uart_param_if.slave bus
);

  localparam int unsigned    OsW      = $clog2(OVERSAMPLE);
  localparam logic [OsW-1:0] OsLast   = OsW'(OVERSAMPLE - 1);
  localparam logic [OsW-1:0] OsMid    = OsW'(OVERSAMPLE / 2 - 1);
  localparam logic [3:0]     DataLast = 4'(DATA_BITS - 1);
  localparam logic [3:0]     StopLast = 4'(STOP_BITS - 1);

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

  logic [15:0] w_period_new;
  assign w_period_new = (i_prescale == 16'd0) ? 16'd1 : i_prescale;

  // ---------------- TX ----------------
  state_e               r_tx_state, w_tx_state;
  logic [15:0]          r_tx_pcnt, w_tx_pcnt, r_tx_period, w_tx_period;
  logic [OsW-1:0]       r_tx_os, w_tx_os;
  logic [3:0]           r_tx_bcnt, w_tx_bcnt;
  logic [DATA_BITS-1:0] r_tx_shift, w_tx_shift;
  logic                 r_tx_par, w_tx_par, r_tx, w_tx, r_tx_busy, w_tx_busy;
  logic                 w_tx_tick, w_tx_bit_end;

  assign w_tx_tick    = (r_tx_pcnt == r_tx_period - 16'd1);
  assign w_tx_bit_end = w_tx_tick && (r_tx_os == OsLast);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_tx_state  <= StIdle;
      r_tx_pcnt   <= '0;
      r_tx_period <= 16'd1;
      r_tx_os     <= '0;
      r_tx_bcnt   <= '0;
      r_tx_shift  <= '0;
      r_tx_par    <= 1'b0;
      r_tx        <= 1'b1;
      r_tx_busy   <= 1'b0;
    end else begin
      r_tx_state  <= w_tx_state;
      r_tx_pcnt   <= w_tx_pcnt;
      r_tx_period <= w_tx_period;
      r_tx_os     <= w_tx_os;
      r_tx_bcnt   <= w_tx_bcnt;
      r_tx_shift  <= w_tx_shift;
      r_tx_par    <= w_tx_par;
      r_tx        <= w_tx;
      r_tx_busy   <= w_tx_busy;
    end
  end

  always_comb begin
    w_tx_state  = r_tx_state;
    w_tx_pcnt   = r_tx_pcnt + 16'd1;
    w_tx_period = r_tx_period;
    w_tx_os     = r_tx_os;
    w_tx_bcnt   = r_tx_bcnt;
    w_tx_shift  = r_tx_shift;
    w_tx_par    = r_tx_par;
    w_tx        = r_tx;
    w_tx_busy   = r_tx_busy;
    // New prescale value is only picked up at a wrap
    if (w_tx_tick) begin
      w_tx_pcnt   = '0;
      w_tx_period = w_period_new;
      w_tx_os     = (r_tx_os == OsLast) ? '0 : r_tx_os + OsW'(1);
    end
    unique case (r_tx_state)
      StIdle: begin
        w_tx = 1'b1;
        if (bus.we) begin
          w_tx_state  = StStart;
          w_tx_shift  = bus.tx_data;
          w_tx_par    = (PARITY == 1) ? ~^bus.tx_data : ^bus.tx_data;
          w_tx        = 1'b0;
          w_tx_busy   = 1'b1;
          w_tx_pcnt   = '0;
          w_tx_period = w_period_new;
          w_tx_os     = '0;
        end
      end
      StStart: begin
        if (w_tx_bit_end) begin
          w_tx_state = StData;
          w_tx       = r_tx_shift[0];
          w_tx_bcnt  = '0;
        end
      end
      StData: begin
        if (w_tx_bit_end) begin
          if (r_tx_bcnt == DataLast) begin
            w_tx_bcnt = '0;
            if (PARITY != 0) begin
              w_tx_state = StParity;
              w_tx       = r_tx_par;
            end else begin
              w_tx_state = StStop;
              w_tx       = 1'b1;
            end
          end else begin
            w_tx_shift = r_tx_shift >> 1;
            w_tx       = r_tx_shift[1];
            w_tx_bcnt  = r_tx_bcnt + 4'd1;
          end
        end
      end
      StParity: begin
        if (w_tx_bit_end) begin
          w_tx_state = StStop;
          w_tx       = 1'b1;
          w_tx_bcnt  = '0;
        end
      end
      StStop: begin
        if (w_tx_bit_end) begin
          if (r_tx_bcnt == StopLast) begin
            w_tx_state = StIdle;
            w_tx_busy  = 1'b0;
          end else begin
            w_tx_bcnt = r_tx_bcnt + 4'd1;
          end
        end
      end
      default: w_tx_state = StIdle;
    endcase
  end

  // ---------------- RX ----------------
  state_e               r_rx_state, w_rx_state;
  logic [15:0]          r_rx_pcnt, w_rx_pcnt, r_rx_period, w_rx_period;
  logic [OsW-1:0]       r_rx_os, w_rx_os;
  logic [3:0]           r_rx_bcnt, w_rx_bcnt;
  logic [DATA_BITS-1:0] r_rx_shift, w_rx_shift, r_rx_data, w_rx_data;
  logic                 r_rx_s1, r_rx_s2, r_rx_armed, w_rx_armed;
  logic                 r_rx_par, w_rx_par, r_rx_valid, w_rx_valid, r_rx_busy, w_rx_busy;
  logic                 r_rx_err, w_rx_err, r_rx_perr, w_rx_perr_o;
  logic                 w_rx_tick, w_rx_mid, w_rx_par_x, w_rx_perr;
`ifdef UART_BREAK_DETECT_EN
  logic                 r_rx_break, w_rx_break, w_rx_brk;
  assign w_rx_brk = (r_rx_shift == '0) && !r_rx_par && !r_rx_s2;
`endif

  assign w_rx_tick  = (r_rx_pcnt == r_rx_period - 16'd1);
  assign w_rx_mid   = w_rx_tick && (r_rx_os == OsMid);
  assign w_rx_par_x = ^{r_rx_shift, r_rx_par};
  assign w_rx_perr  = (PARITY == 1) ? ~w_rx_par_x : (PARITY == 2) ? w_rx_par_x : 1'b0;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      // Sync flops clear low so a line held low through reset cannot fake a start
      r_rx_s1     <= 1'b0;
      r_rx_s2     <= 1'b0;
      r_rx_armed  <= 1'b0;
      r_rx_state  <= StIdle;
      r_rx_pcnt   <= '0;
      r_rx_period <= 16'd1;
      r_rx_os     <= '0;
      r_rx_bcnt   <= '0;
      r_rx_shift  <= '0;
      r_rx_par    <= 1'b0;
      r_rx_data   <= '0;
      r_rx_valid  <= 1'b0;
      r_rx_busy   <= 1'b0;
      r_rx_err    <= 1'b0;
      r_rx_perr   <= 1'b0;
`ifdef UART_BREAK_DETECT_EN
      r_rx_break  <= 1'b0;
`endif
    end else begin
      r_rx_s1     <= i_rx;
      r_rx_s2     <= r_rx_s1;
      r_rx_armed  <= w_rx_armed;
      r_rx_state  <= w_rx_state;
      r_rx_pcnt   <= w_rx_pcnt;
      r_rx_period <= w_rx_period;
      r_rx_os     <= w_rx_os;
      r_rx_bcnt   <= w_rx_bcnt;
      r_rx_shift  <= w_rx_shift;
      r_rx_par    <= w_rx_par;
      r_rx_data   <= w_rx_data;
      r_rx_valid  <= w_rx_valid;
      r_rx_busy   <= w_rx_busy;
      r_rx_err    <= w_rx_err;
      r_rx_perr   <= w_rx_perr_o;
`ifdef UART_BREAK_DETECT_EN
      r_rx_break  <= w_rx_break;
`endif
    end
  end

  always_comb begin
    w_rx_state  = r_rx_state;
    w_rx_armed  = r_rx_armed;
    w_rx_pcnt   = r_rx_pcnt + 16'd1;
    w_rx_period = r_rx_period;
    w_rx_os     = r_rx_os;
    w_rx_bcnt   = r_rx_bcnt;
    w_rx_shift  = r_rx_shift;
    w_rx_par    = r_rx_par;
    w_rx_data   = r_rx_data;
    w_rx_valid  = 1'b0;
    w_rx_busy   = r_rx_busy;
    w_rx_err    = r_rx_err;
    w_rx_perr_o = r_rx_perr;
`ifdef UART_BREAK_DETECT_EN
    w_rx_break  = 1'b0;
`endif
    if (w_rx_tick) begin
      w_rx_pcnt   = '0;
      w_rx_period = w_period_new;
      w_rx_os     = (r_rx_os == OsLast) ? '0 : r_rx_os + OsW'(1);
    end
    unique case (r_rx_state)
      StIdle: begin
        // Armed only once the line has been seen high; a start is a low after that
        if (!r_rx_armed) begin
          w_rx_armed = r_rx_s2;
        end else if (!r_rx_s2) begin
          w_rx_state  = StStart;
          w_rx_armed  = 1'b0;
          w_rx_busy   = 1'b1;
          w_rx_pcnt   = '0;
          w_rx_period = w_period_new;
          w_rx_os     = '0;
        end
      end
      StStart: begin
        if (w_rx_mid) begin
          if (r_rx_s2) begin
            w_rx_state = StIdle;
            w_rx_busy  = 1'b0;
          end else begin
            w_rx_state = StData;
            w_rx_bcnt  = '0;
          end
        end
      end
      StData: begin
        if (w_rx_mid) begin
          w_rx_shift = {r_rx_s2, r_rx_shift[DATA_BITS-1:1]};
          if (r_rx_bcnt == DataLast) begin
            w_rx_state = (PARITY != 0) ? StParity : StStop;
          end else begin
            w_rx_bcnt = r_rx_bcnt + 4'd1;
          end
        end
      end
      StParity: begin
        if (w_rx_mid) begin
          w_rx_par   = r_rx_s2;
          w_rx_state = StStop;
        end
      end
      StStop: begin
        if (w_rx_mid) begin
          w_rx_state  = StIdle;
          w_rx_valid  = 1'b1;
          w_rx_busy   = 1'b0;
          w_rx_data   = r_rx_shift;
          w_rx_err    = ~r_rx_s2 | w_rx_perr;
          w_rx_perr_o = w_rx_perr;
`ifdef UART_BREAK_DETECT_EN
          w_rx_break  = w_rx_brk;
          if (w_rx_brk) w_rx_err = 1'b1;
`endif
        end
      end
      default: w_rx_state = StIdle;
    endcase
  end

  assign o_tx              = r_tx;
  assign bus.tx_busy       = r_tx_busy;
  assign bus.rx_data       = r_rx_data;
  assign bus.rx_valid      = r_rx_valid;
  assign bus.rx_busy       = r_rx_busy;
  assign bus.rx_error      = r_rx_err;
  assign bus.rx_parity_err = r_rx_perr;
`ifdef UART_BREAK_DETECT_EN
  assign bus.rx_break      = r_rx_break;
`endif

endmodule

// File: tb/tb_uart_param.sv
// Directed bench for uart_param: three instances (8N1, 7E1 loopback, 8O1) at prescale 4.
module tb_uart_param;

  logic        clk;
  logic        rst_a, rst_bc;
  logic [15:0] prescale;
  logic        tx_a, rx_a, tx_b, rx_b, tx_c, rx_c;
  int          n_total = 0;
  int          n_bad   = 0;
  int          nv_a = 0, nv_b = 0, nv_c = 0;

  uart_param_if #(.DATA_BITS(8)) if_a ();
  uart_param_if #(.DATA_BITS(7)) if_b ();
  uart_param_if #(.DATA_BITS(8)) if_c ();

  uart_param #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .OVERSAMPLE(16)) u_a (
    .i_clk(clk), .i_reset(rst_a), .i_prescale(prescale), .o_tx(tx_a), .i_rx(rx_a), .bus(if_a)
  );
  uart_param #(.DATA_BITS(7), .PARITY(2), .STOP_BITS(1), .OVERSAMPLE(16)) u_b (
    .i_clk(clk), .i_reset(rst_bc), .i_prescale(prescale), .o_tx(tx_b), .i_rx(rx_b), .bus(if_b)
  );
  uart_param #(.DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .OVERSAMPLE(16)) u_c (
    .i_clk(clk), .i_reset(rst_bc), .i_prescale(prescale), .o_tx(tx_c), .i_rx(rx_c), .bus(if_c)
  );

  assign rx_b = tx_b;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (if_a.rx_valid) nv_a <= nv_a + 1;
    if (if_b.rx_valid) nv_b <= nv_b + 1;
    if (if_c.rx_valid) nv_c <= nv_c + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic busy_of(input int sel);
    if (sel == 0) return if_a.tx_busy;
    if (sel == 1) return if_b.tx_busy;
    return if_c.tx_busy;
  endfunction

  task automatic wait_idle(input int sel, input int budget);
    logic b;
    b = busy_of(sel);
    for (int k = 0; k < budget && b; k++) begin
      @(posedge clk); #1;
      b = busy_of(sel);
    end
    check_eq($sformatf("tx%0d_idle_wait", sel), b, 0);
  endtask

  task automatic rx_bit(input int sel, input logic v, input int n);
    if (sel == 0) rx_a = v;
    else          rx_c = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic rx_frame(input int sel, input logic [7:0] data, input bit has_par,
                          input logic par, input logic stop);
    rx_bit(sel, 1'b0, 64);
    for (int i = 0; i < 8; i++) rx_bit(sel, data[i], 64);
    if (has_par) rx_bit(sel, par, 64);
    rx_bit(sel, stop, 64);
  endtask

  // Launch a TX frame on u_a (sel 0) or u_c (sel 2) and check it bit by bit at mid-bit.
  // On u_c also poke we mid-frame, on the falling-busy cycle, and on the first idle cycle.
  task automatic tx_check(input int sel, input logic [7:0] data, input logic [10:0] exp_bits,
                          input int nb);
    int   busy_n;
    logic cur_tx, cur_busy;
    busy_n = 0;
    if (sel == 0) begin if_a.tx_data = data; if_a.we = 1'b1; end
    else          begin if_c.tx_data = data; if_c.we = 1'b1; end
    for (int i = 0; i <= nb * 64 + 1; i++) begin
      @(posedge clk); #1;
      cur_tx   = (sel == 0) ? tx_a : tx_c;
      cur_busy = busy_of(sel);
      if (i == 0) begin if_a.we = 1'b0; if_c.we = 1'b0; end
      if (i < nb * 64 && (i % 64) == 32)
        check_eq($sformatf("tx%0d_bit%0d", sel, i / 64), cur_tx, exp_bits[i / 64]);
      if (i < nb * 64) busy_n += cur_busy;
      if (i == nb * 64) begin
        check_eq($sformatf("tx%0d_busy_fall", sel), cur_busy, 0);
        check_eq($sformatf("tx%0d_idle_line", sel), cur_tx, 1);
      end
      if (sel == 2) begin
        if (i == 100) begin if_c.we = 1'b1; if_c.tx_data = 8'h00; end
        if (i == 101) if_c.we = 1'b0;
        if (i == nb * 64 - 1) if_c.we = 1'b1;
        if (i == nb * 64 + 1) begin
          check_eq("tx2_first_idle_accept_busy", cur_busy, 1);
          check_eq("tx2_first_idle_accept_start", cur_tx, 0);
          if_c.we = 1'b0;
        end
      end
    end
    check_eq($sformatf("tx%0d_busy_len", sel), busy_n, nb * 64);
  endtask

  initial begin
    logic [10:0] exp_bits;
    rst_a = 1'b1; rst_bc = 1'b1; prescale = 16'd4; rx_a = 1'b1; rx_c = 1'b1;
    if_a.we = 1'b0; if_a.tx_data = '0;
    if_b.we = 1'b0; if_b.tx_data = '0;
    if_c.we = 1'b0; if_c.tx_data = '0;
    repeat (3) @(posedge clk);
    #1;
    rst_a = 1'b0; rst_bc = 1'b0;

    check_eq("rst_tx",        tx_a, 1);
    check_eq("rst_tx_busy",   if_a.tx_busy, 0);
    check_eq("rst_rx_data",   if_a.rx_data, 0);
    check_eq("rst_rx_valid",  if_a.rx_valid, 0);
    check_eq("rst_rx_busy",   if_a.rx_busy, 0);
    check_eq("rst_rx_error",  if_a.rx_error, 0);
    check_eq("rst_rx_perr",   if_a.rx_parity_err, 0);
    check_eq("rst_b_rx_data", if_b.rx_data, 0);
    repeat (10) @(posedge clk);
    #1;

    // 8N1 0x55: start, 1,0,1,0,1,0,1,0, stop
    exp_bits = {1'b0, 1'b0, 1'b1, 8'h55, 1'b0};
    tx_check(0, 8'h55, exp_bits, 10);

    // 8O1 0x0F: odd parity bit = 1; we mid-frame with 0x00 must not disturb it
    exp_bits = {1'b1, 1'b1, 8'h0F, 1'b0};
    tx_check(2, 8'h0F, exp_bits, 11);
    wait_idle(2, 1000);

    // 7E1 loopback 0x3A
    if_b.tx_data = 7'h3A; if_b.we = 1'b1;
    @(posedge clk); #1;
    if_b.we = 1'b0;
    wait_idle(1, 2000);
    repeat (4) @(posedge clk);
    #1;
    check_eq("b_valid_cnt", nv_b, 1);
    check_eq("b_rx_data",   if_b.rx_data, 7'h3A);
    check_eq("b_rx_error",  if_b.rx_error, 0);
    check_eq("b_rx_perr",   if_b.rx_parity_err, 0);

    // prescale 0 behaves as 1 (16 clk per bit)
    prescale = 16'd0;
    if_b.tx_data = 7'h55; if_b.we = 1'b1;
    @(posedge clk); #1;
    if_b.we = 1'b0;
    repeat (100) @(posedge clk);
    #1;
    check_eq("b_ps0_busy_mid", if_b.tx_busy, 1);
    repeat (70) @(posedge clk);
    #1;
    check_eq("b_ps0_done", if_b.tx_busy, 0);
    check_eq("b_ps0_valid_cnt", nv_b, 2);
    check_eq("b_ps0_rx_data", if_b.rx_data, 7'h55);
    prescale = 16'd4;
    repeat (10) @(posedge clk);
    #1;

    // 8O1 RX with wrong parity, then correct parity
    rx_frame(2, 8'h0F, 1'b1, 1'b0, 1'b1);
    repeat (10) @(posedge clk);
    #1;
    check_eq("c_bad_par_cnt",  nv_c, 1);
    check_eq("c_bad_par_data", if_c.rx_data, 8'h0F);
    check_eq("c_bad_par_perr", if_c.rx_parity_err, 1);
    check_eq("c_bad_par_err",  if_c.rx_error, 1);
    rx_frame(2, 8'h0F, 1'b1, 1'b1, 1'b1);
    repeat (10) @(posedge clk);
    #1;
    check_eq("c_ok_par_cnt",  nv_c, 2);
    check_eq("c_ok_par_perr", if_c.rx_parity_err, 0);
    check_eq("c_ok_par_err",  if_c.rx_error, 0);

    // 8N1 0xA5 with stop forced low; line then held low
    rx_frame(0, 8'hA5, 1'b0, 1'b0, 1'b0);
    check_eq("a_frm_cnt",  nv_a, 1);
    check_eq("a_frm_data", if_a.rx_data, 8'hA5);
    check_eq("a_frm_err",  if_a.rx_error, 1);
    check_eq("a_frm_perr", if_a.rx_parity_err, 0);
    repeat (300) @(posedge clk);
    #1;
    check_eq("a_no_rearm_busy", if_a.rx_busy, 0);
    check_eq("a_no_rearm_cnt",  nv_a, 1);
    rx_bit(0, 1'b1, 64);
    rx_frame(0, 8'h3C, 1'b0, 1'b0, 1'b1);
    check_eq("a_rearm_cnt",  nv_a, 2);
    check_eq("a_rearm_data", if_a.rx_data, 8'h3C);
    check_eq("a_rearm_err",  if_a.rx_error, 0);
    repeat (20) @(posedge clk);
    #1;

    // 20-clk glitch: start seen 3 clk in, rejected at the start-bit midpoint (clk 35)
    rx_a = 1'b0;
    for (int j = 1; j <= 200; j++) begin
      @(posedge clk); #1;
      if (j == 20) rx_a = 1'b1;
      if (j == 5)  check_eq("glitch_busy_set",  if_a.rx_busy, 1);
      if (j == 33) check_eq("glitch_busy_hold", if_a.rx_busy, 1);
      if (j == 37) check_eq("glitch_busy_drop", if_a.rx_busy, 0);
    end
    check_eq("glitch_no_valid", nv_a, 2);

    // Reset during TX bit 4 and during an RX frame
    if_a.tx_data = 8'h55; if_a.we = 1'b1; rx_a = 1'b0;
    for (int j = 0; j < 4 * 64 + 20; j++) begin
      @(posedge clk); #1;
      if (j == 0) if_a.we = 1'b0;
    end
    check_eq("pre_rst_tx_busy", if_a.tx_busy, 1);
    check_eq("pre_rst_rx_busy", if_a.rx_busy, 1);
    rst_a = 1'b1; rx_a = 1'b1;
    @(posedge clk); #1;
    rst_a = 1'b0;
    check_eq("mid_rst_tx",      tx_a, 1);
    check_eq("mid_rst_tx_busy", if_a.tx_busy, 0);
    check_eq("mid_rst_rx_busy", if_a.rx_busy, 0);
    repeat (800) @(posedge clk);
    #1;
    check_eq("post_rst_no_valid", nv_a, 2);
    check_eq("post_rst_tx_idle",  if_a.tx_busy, 0);
    check_eq("post_rst_tx_line",  tx_a, 1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_param.md
Name: uart_param

Overview:
- Parametrised full-duplex UART with independent TX and RX engines sharing one baud prescaler input.
- Data width, parity mode, stop-bit count and oversampling factor are set by parameters.
- Adds frame/parity error reporting and a one-cycle receive-valid strobe.
- Sits between the MCU bus peripheral register block and the external pins.

Parameters:
- DATA_BITS, 8, data bits per frame; legal 5..9.
- PARITY, 0, 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1, TX stop bits (1 or 2). RX always checks only the first stop bit.
- OVERSAMPLE, 16, oversample ticks per bit; even, >= 8.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- prescale  in  16  clk cycles per oversample tick; 0 is treated as 1
- we  in  1  TX write strobe; accepted only when tx_busy = 0
- tx_data  in  DATA_BITS  TX payload
- tx  out  1  serial output; idles high
- tx_busy  out  1  high while a frame is in flight
- rx  in  1  serial input; asynchronous
- rx_data  out  DATA_BITS  last received payload; held until the next frame completes
- rx_valid  out  1  one-cycle pulse when a frame completes
- rx_busy  out  1  high from start detection to the end of the stop bit
- rx_error  out  1  frame or parity error of the last frame; updated with rx_valid
- rx_parity_err  out  1  parity error of the last frame; 0 when PARITY = 0

Behaviour:
- Reset: tx=1, tx_busy=0, rx_data=0, rx_valid=0, rx_busy=0, rx_error=0, rx_parity_err=0. All counters and FSMs return to IDLE.
- Reset mid-frame aborts the frame immediately. tx=1 on the next edge; no rx_valid is produced.
- Tick generator:
  - Free-running 16-bit counter. A tick is asserted for 1 cycle every max(prescale,1) clocks.
  - A prescale change takes effect when the counter next wraps.
  - One bit period = OVERSAMPLE ticks.
  - TX and RX each keep their own tick-phase counters.
- TX FSM: IDLE -> START -> DATA -> PARITY (skipped if PARITY=0) -> STOP -> IDLE.
  - we with tx_busy=0 latches tx_data. tx_busy=1 and tx=0 on the next clk edge.
  - START lasts a full bit period from that edge.
  - DATA sends LSB first, DATA_BITS bits.
  - Parity bit: odd mode = ~^data, even mode = ^data.
  - STOP drives 1 for STOP_BITS bit periods. tx_busy falls on the cycle the last stop bit ends.
  - we while tx_busy=1 is ignored; the latched data is unchanged.
  - we in the same cycle tx_busy falls is ignored. we on the first cycle with tx_busy=0 is accepted.
- RX:
  - rx passes through a 2-flop synchroniser; all decisions use the synchronised signal.
  - FSM: IDLE -> START -> DATA -> PARITY (skipped if PARITY=0) -> STOP -> IDLE.
  - IDLE: a falling edge (1 -> 0) enters START and sets rx_busy=1.
  - START: sample at tick OVERSAMPLE/2. If the line is 1, treat it as a glitch: return to IDLE, rx_busy=0, no rx_valid.
  - DATA and PARITY bits are sampled at mid-bit, every OVERSAMPLE ticks after the start-bit midpoint.
  - STOP is sampled at mid-bit. On the same cycle:
    - rx_valid pulses for 1 cycle, rx_data updates, and rx_busy falls.
    - rx_error = (stop==0) | parity_err.
    - rx_parity_err = parity_err.
  - Data is delivered even when an error is flagged.
  - After a stop=0 frame, RX returns to IDLE but does not rearm until the line has been seen high.
- TX and RX are fully independent; simultaneous activity is required.

Optional Feature:
- Macro: UART_BREAK_DETECT_EN.
- Defined:
  - Adds output rx_break (1 bit, reset 0).
  - When a received frame has all data bits 0, parity bit 0 (if present) and stop = 0, rx_break pulses 1 cycle coincident with rx_valid.
  - rx_error is also set in that case.
- Not defined:
  - The rx_break port does not exist.
  - A break is reported only as a framing error.

Test Plan:
- Default params, prescale=4 (64 clk/bit), we with tx_data=0x55 -> tx shows 0,1,0,1,0,1,0,1,0,1 then 1, each bit 64 clks. tx_busy high for exactly 640 clks.
- TX looped to RX, PARITY=2, DATA_BITS=7, tx_data=0x3A -> rx_valid pulse, rx_data=0x3A, rx_error=0, rx_parity_err=0.
- RX driven with 8N1 0xA5 but stop bit forced 0 -> rx_valid, rx_data=0xA5, rx_error=1. No new start is detected until rx returns high.
- 20-clk low glitch on idle rx at prescale=4 -> no rx_valid; rx_busy returns to 0 at the start-bit midpoint check.
- PARITY=1, frame 0x0F sent with a wrong parity bit -> rx_parity_err=1, rx_error=1. A second we during tx_busy is ignored; the tx waveform is unchanged.
- Reset asserted mid-TX at bit 4 and mid-RX -> next cycle tx=1, tx_busy=0, rx_busy=0, and no rx_valid follows.
